// File: rtl/alu_seq16.sv
// Nibble-serial ALU sequencer: walks W-bit operands through one external 4-bit ALU
// slice, LSB nibble first, chaining the slice carry through a register.
module alu_seq16 #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic [2:0]           req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_f,
    output logic                 rsp_cout,
    output logic                 rsp_zero,
    output logic                 rsp_ovf,
    output logic                 rsp_err,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_cn,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cout
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ERR  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             is_arith;
    logic             is_sub;

    assign is_sub   = (op_q == OP_SUB);
    assign is_arith = (op_q == OP_ADD) || is_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        result_d  = result_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_s     = 4'h0;
        alu_m     = 1'b1;
        alu_cn    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d      = req_a;
                    b_d      = req_b;
                    op_d     = req_op;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = (req_op <= OP_NAND) ? EXEC : ERR;
                end
            end
            EXEC: begin
                alu_a  = a_q[{idx_q, 2'b00} +: 4];
                alu_b  = b_q[{idx_q, 2'b00} +: 4];
                alu_m  = !is_arith;
                // Logic ops 2..5 map onto slice selects 0..3.
                alu_s  = is_arith ? {3'b000, is_sub} : {1'b0, op_q - 3'd2};
                alu_cn = (idx_q == '0) ? is_sub : (is_arith & carry_q);
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[4*i +: 4] = alu_f;
                    end
                end
                carry_d = alu_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                    cout_d  = is_arith & alu_cout;
                    zero_d  = (result_d == '0);
                    // Top nibble result is still on alu_f this cycle.
                    ovf_d   = is_arith
                            && ((a_q[W-1] ^ b_q[W-1]) == is_sub)
                            && (alu_f[3] != a_q[W-1]);
                end
            end
            ERR: begin
                state_d = DONE;
                err_d   = 1'b1;
                zero_d  = 1'b1;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_f    = result_q;
    assign rsp_cout = cout_q;
    assign rsp_zero = zero_q;
    assign rsp_ovf  = ovf_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: behavioural 4-bit slice, table of directed operations,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_seq16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [2:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_f;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic        alu_cn;
    logic [3:0]  alu_f;
    logic        alu_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq16 #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_cn(alu_cn), .alu_f(alu_f), .alu_cout(alu_cout)
    );

    // External slice, written from its stated contract.
    always_comb begin
        alu_f    = 4'h0;
        alu_cout = 1'b0;
        if (!alu_m) begin
            {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b ^ {4{alu_s[0]}}} + {4'b0000, alu_cn};
        end else begin
            case (alu_s[1:0])
                2'd0: alu_f = alu_a & alu_b;
                2'd1: alu_f = alu_a | alu_b;
                2'd2: alu_f = alu_a ^ alu_b;
                default: alu_f = ~(alu_a & alu_b);
            endcase
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] f;
        logic        cout;
        logic        zero;
        logic        ovf;
        logic        err;
        logic [3:0]  s;
    } vec_t;

    vec_t       vecs[13];
    logic [3:0] seq_a[8];
    logic       seq_cn[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int id);
        int   n;
        int   lat;
        int   nexec;
        logic ctl_ok;
        logic exp_m;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d ready", id), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        exp_m  = !(v.op == 3'd0 || v.op == 3'd1);
        lat    = 0;
        nexec  = 0;
        ctl_ok = 1'b1;
        while (!rsp_valid && lat < 20) begin
            if (nexec < 8) begin
                seq_a[nexec]  = alu_a;
                seq_cn[nexec] = alu_cn;
            end
            if (alu_m !== exp_m || alu_s !== v.s) ctl_ok = 1'b0;
            nexec++;
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", id), lat, v.err ? 32'd1 : 32'd4);
        check($sformatf("v%0d slice_ctl", id), {31'b0, ctl_ok}, 32'd1);
        check($sformatf("v%0d rsp_f", id), {16'b0, rsp_f}, {16'b0, v.f});
        check($sformatf("v%0d flags(cout,zero,ovf,err)", id),
              {28'b0, rsp_cout, rsp_zero, rsp_ovf, rsp_err},
              {28'b0, v.cout, v.zero, v.ovf, v.err});
        check($sformatf("v%0d ready_in_done", id), {31'b0, req_ready}, 32'd0);
        $display("op=%0d a=%h b=%h -> f=%h cout=%b zero=%b ovf=%b err=%b lat=%0d",
                 v.op, v.a, v.b, rsp_f, rsp_cout, rsp_zero, rsp_ovf, rsp_err, lat);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d post_handshake", id), {30'b0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        vecs[0]  = '{3'd0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[2]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1};
        vecs[3]  = '{3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1};
        vecs[4]  = '{3'd4, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2};
        vecs[5]  = '{3'd6, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0};
        vecs[6]  = '{3'd5, 16'hFF00, 16'h0FF0, 16'hF0FF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3};
        vecs[7]  = '{3'd2, 16'h1234, 16'h0FCD, 16'h0204, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[8]  = '{3'd3, 16'h1234, 16'h0FCD, 16'h1FFD, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1};
        vecs[9]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
        vecs[10] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0};
        vecs[11] = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1};
        vecs[12] = '{3'd2, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rsp/ready", {26'b0, req_ready, rsp_valid, rsp_cout, rsp_zero, rsp_ovf, rsp_err},
              32'h20);
        check("reset rsp_f", {16'b0, rsp_f}, 32'd0);
        check("reset alu", {22'b0, alu_a, alu_b, alu_s, alu_m, alu_cn}, 32'h2);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i], i);
            if (i == 0) begin
                check("alu_a sequence", {16'b0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'h4321);
                check("alu_cn sequence", {28'b0, seq_cn[0], seq_cn[1], seq_cn[2], seq_cn[3]}, 32'b0111);
            end
        end

        // Backpressure: response held while rsp_ready stays low.
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'h0003;
        req_b     = 16'h0004;
        @(posedge clk);
        @(negedge clk);
        req_op = 3'd4;
        req_a  = 16'hFFFF;
        req_b  = 16'h1111;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp rsp_valid", {31'b0, rsp_valid}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp hold%0d", c),
                  {12'b0, rsp_f, rsp_valid, req_ready, rsp_cout, rsp_zero},
                  {12'b0, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0});
            @(negedge clk);
        end
        $display("backpressure: held f=%h for 3 cycles", rsp_f);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("bp release", {30'b0, rsp_valid, req_ready}, 32'd1);
        @(negedge clk);

        // Reset in the second EXEC cycle abandons the operation.
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'h1111;
        req_b     = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst rsp", {26'b0, req_ready, rsp_valid, rsp_cout, rsp_zero, rsp_ovf, rsp_err},
              32'h20);
        check("async rst rsp_f", {16'b0, rsp_f}, 32'd0);
        check("async rst alu", {22'b0, alu_a, alu_b, alu_s, alu_m, alu_cn}, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no rsp after reset", seen, 32'd0);
        $display("reset mid-exec: outputs cleared, no response emitted");
        run_op('{3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
